// File: rtl/hazard_scoreboard_if.sv
// D-stage decode information into the hazard scoreboard, and the stall/forward
// decisions back out to the pipeline.
interface hazard_scoreboard_if #(
    parameter int TW   = 3,
    parameter int SELW = 2
);
    logic            d_valid;
    logic [4:0]      d_rs;
    logic [4:0]      d_rt;
    logic [TW-1:0]   d_tuse_rs;
    logic [TW-1:0]   d_tuse_rt;
    logic [4:0]      d_dst;
    logic [TW-1:0]   d_tnew;
    logic            d_md_use;
    logic            d_md_start;
    logic            d_md_div;

    logic            stall;
    logic [SELW-1:0] fwd_rs_d;
    logic [SELW-1:0] fwd_rt_d;
    logic [SELW-1:0] fwd_rs_e;
    logic [SELW-1:0] fwd_rt_e;
    logic            md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_use, d_md_start, d_md_div,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_use, d_md_start, d_md_div,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Registered scoreboard of in-flight writers past Decode: derives D/E forward
// selects and the D stall, and owns the multiply/divide busy counter.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SELW     = $clog2(NSTAGE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
);
    localparam int MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef struct packed {
        logic            hit;
        logic [TW-1:0]   tnew;
        logic [SELW-1:0] k;
    } match_t;

    // Index 0 is the E entry, index NSTAGE-1 the W entry.
    logic [4:0]    dst_q  [NSTAGE];
    logic [4:0]    dst_d  [NSTAGE];
    logic [TW-1:0] tnew_q [NSTAGE];
    logic [TW-1:0] tnew_d [NSTAGE];
    logic [4:0]    rs_q   [NSTAGE];
    logic [4:0]    rs_d   [NSTAGE];
    logic [4:0]    rt_q   [NSTAGE];
    logic [4:0]    rt_d   [NSTAGE];
    logic          md_tag_q;
    logic          md_tag_d;
    logic [CW-1:0] md_cnt_q;
    logic [CW-1:0] md_cnt_d;

    match_t m_rs_d, m_rt_d, m_rs_e, m_rt_e;
    logic   rs_stall, rt_stall, md_stall, stall, issue, md_busy;

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    function automatic match_t youngest(input logic [4:0] x, input int kmin);
        match_t m;
        m = '0;
        for (int k = NSTAGE; k >= kmin; k--) begin
            if (x != 5'd0 && dst_q[k-1] == x) begin
                m.hit  = 1'b1;
                m.tnew = tnew_q[k-1];
                m.k    = SELW'(k);
            end
        end
        return m;
    endfunction

    always_comb begin
        m_rs_d = youngest(sb.d_rs, 1);
        m_rt_d = youngest(sb.d_rt, 1);
        m_rs_e = youngest(rs_q[0], 2);
        m_rt_e = youngest(rt_q[0], 2);
    end

    assign rs_stall = m_rs_d.hit && (m_rs_d.tnew > sb.d_tuse_rs);
    assign rt_stall = m_rt_d.hit && (m_rt_d.tnew > sb.d_tuse_rt);
    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = sb.d_md_use && (md_busy || md_tag_q);
    assign stall    = rs_stall || rt_stall || md_stall;
    assign issue    = sb.d_valid && !stall;

    assign sb.stall    = stall;
    assign sb.md_busy  = md_busy;
    assign sb.fwd_rs_d = (m_rs_d.hit && m_rs_d.tnew == '0) ? m_rs_d.k : '0;
    assign sb.fwd_rt_d = (m_rt_d.hit && m_rt_d.tnew == '0) ? m_rt_d.k : '0;
    assign sb.fwd_rs_e = (m_rs_e.hit && m_rs_e.tnew == '0) ? m_rs_e.k : '0;
    assign sb.fwd_rt_e = (m_rt_e.hit && m_rt_e.tnew == '0) ? m_rt_e.k : '0;

    // A stalled D inserts a bubble into E while E/M/W keep advancing.
    always_comb begin
        dst_d[0]  = issue ? sb.d_dst  : '0;
        tnew_d[0] = issue ? sb.d_tnew : '0;
        rs_d[0]   = issue ? sb.d_rs   : '0;
        rt_d[0]   = issue ? sb.d_rt   : '0;
        for (int k = 1; k < NSTAGE; k++) begin
            dst_d[k]  = dst_q[k-1];
            tnew_d[k] = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TW'(1) : '0;
            rs_d[k]   = rs_q[k-1];
            rt_d[k]   = rt_q[k-1];
        end
        md_tag_d = issue && sb.d_md_start;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue && sb.d_md_start) begin
            md_cnt_d = sb.d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                dst_q[k]  <= '0;
                tnew_q[k] <= '0;
                rs_q[k]   <= '0;
                rt_q[k]   <= '0;
            end
            md_tag_q <= 1'b0;
            md_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                dst_q[k]  <= dst_d[k];
                tnew_q[k] <= tnew_d[k];
                rs_q[k]   <= rs_d[k];
                rt_q[k]   <= rt_d[k];
            end
            md_tag_q <= md_tag_d;
            md_cnt_q <= md_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, multi-cycle MD/reset
// sequences, and random traffic against an age-based reference model.
module tb_hazard_scoreboard;
    localparam int NSTAGE   = 3;
    localparam int TW       = 3;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int SELW     = 2;
    localparam int NVEC     = 12;

    logic clk = 1'b0;
    logic reset;

    hazard_scoreboard_if #(.TW(TW), .SELW(SELW)) sb ();

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .SELW(SELW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [2:0] tu_rs;
        logic [2:0] tu_rt;
        logic [4:0] dst;
        logic [2:0] tnew;
        logic       mu;
        logic       ms;
        logic       md;
        logic       e_stall;
        logic [1:0] e_frs_d;
        logic [1:0] e_frt_d;
        logic [1:0] e_frs_e;
        logic [1:0] e_frt_e;
        logic       e_busy;
    } vec_t;

    vec_t tbl [NVEC];

    // Reference model: every issued instruction with the cycle it left D.
    typedef struct {
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        int         tnew;
        bit         md;
        int         issue;
    } fl_t;

    fl_t fl[$];
    int  cyc;
    int  busy_until;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [2:0] tu_rs, input logic [2:0] tu_rt,
                         input logic [4:0] dst, input logic [2:0] tnew,
                         input logic mu, input logic ms, input logic md);
        sb.d_valid    = v;
        sb.d_rs       = rs;
        sb.d_rt       = rt;
        sb.d_tuse_rs  = tu_rs;
        sb.d_tuse_rt  = tu_rt;
        sb.d_dst      = dst;
        sb.d_tnew     = tnew;
        sb.d_md_use   = mu;
        sb.d_md_start = ms;
        sb.d_md_div   = md;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all(input string tag, input logic st, input logic [1:0] a,
                             input logic [1:0] b, input logic [1:0] c, input logic [1:0] d,
                             input logic busy);
        chk({tag, ".stall"}, 32'(sb.stall), 32'(st));
        chk({tag, ".fwd_rs_d"}, 32'(sb.fwd_rs_d), 32'(a));
        chk({tag, ".fwd_rt_d"}, 32'(sb.fwd_rt_d), 32'(b));
        chk({tag, ".fwd_rs_e"}, 32'(sb.fwd_rs_e), 32'(c));
        chk({tag, ".fwd_rt_e"}, 32'(sb.fwd_rt_e), 32'(d));
        chk({tag, ".md_busy"}, 32'(sb.md_busy), 32'(busy));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void find(input logic [4:0] x, input int smin,
                                 output int s_hit, output int r_hit);
        s_hit = 0;
        r_hit = 0;
        if (x == 5'd0) return;
        foreach (fl[i]) begin
            int s;
            int r;
            s = cyc - fl[i].issue;
            r = fl[i].tnew - (s - 1);
            if (s >= smin && s <= NSTAGE && fl[i].dst == x && (s_hit == 0 || s < s_hit)) begin
                s_hit = s;
                r_hit = (r < 0) ? 0 : r;
            end
        end
    endfunction

    task automatic model_step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input int tu_rs, input int tu_rt, input logic [4:0] dst,
                              input int tnew, input logic mu, input logic ms, input logic md,
                              input string tag);
        int s, r;
        logic st, busy, e1md;
        logic [1:0] frs_d, frt_d, frs_e, frt_e;
        logic [4:0] ers, ert;
        logic st_rs, st_rt;

        find(rs, 1, s, r);
        st_rs = (s != 0) && (r > tu_rs);
        frs_d = (s != 0 && r == 0) ? 2'(s) : 2'd0;
        find(rt, 1, s, r);
        st_rt = (s != 0) && (r > tu_rt);
        frt_d = (s != 0 && r == 0) ? 2'(s) : 2'd0;

        ers = 5'd0;
        ert = 5'd0;
        e1md = 1'b0;
        foreach (fl[i]) begin
            if (cyc - fl[i].issue == 1) begin
                ers  = fl[i].rs;
                ert  = fl[i].rt;
                e1md = fl[i].md;
            end
        end
        find(ers, 2, s, r);
        frs_e = (s != 0 && r == 0) ? 2'(s) : 2'd0;
        find(ert, 2, s, r);
        frt_e = (s != 0 && r == 0) ? 2'(s) : 2'd0;

        busy = (cyc <= busy_until);
        st   = st_rs || st_rt || (mu && (busy || e1md));

        @(negedge clk);
        check_all(tag, st, frs_d, frt_d, frs_e, frt_e, busy);

        if (v && !st) begin
            fl.push_back('{dst: dst, rs: rs, rt: rt, tnew: tnew, md: ms, issue: cyc});
            if (ms) busy_until = cyc + (md ? DIV_LAT : MULT_LAT);
        end
        while (fl.size() > 0 && (cyc + 1 - fl[0].issue) > NSTAGE) void'(fl.pop_front());
    endtask

    task automatic md_seq(input bit is_div, input string nm);
        int lat;
        int st_cnt;
        int busy_cnt;
        bit issued;
        lat      = is_div ? DIV_LAT : MULT_LAT;
        st_cnt   = 0;
        busy_cnt = 0;
        issued   = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 1'b1, 1'b1, is_div);
        @(negedge clk);
        chk({nm, ".start_stall"}, 32'(sb.stall), 32'd0);
        chk({nm, ".start_busy"}, 32'(sb.md_busy), 32'd0);
        next_cycle();
        // mflo waits behind the running MD operation
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd8, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < lat + 6 && !issued; i++) begin
            @(negedge clk);
            if (sb.stall) st_cnt++;
            if (sb.md_busy) busy_cnt++;
            if (!sb.stall) begin
                issued = 1'b1;
                chk({nm, ".busy_at_issue"}, 32'(sb.md_busy), 32'd0);
            end
            next_cycle();
        end
        chk({nm, ".mflo_issued"}, 32'(issued), 32'd1);
        chk({nm, ".stall_cycles"}, 32'(st_cnt), 32'(lat));
        chk({nm, ".busy_cycles"}, 32'(busy_cnt), 32'(lat));
        drive_idle();
        repeat (NSTAGE + 1) next_cycle();
    endtask

    initial begin
        //            v  rs rt trs trt dst tn mu ms md | st frsd frtd frse frte busy
        tbl[0]  = '{1, 1'b0 ? 5'd0 : 5'd2, 0, 1, 7, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
        tbl[4]  = '{1, 6, 7, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0};
        tbl[6]  = '{1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 7, 7, 4, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
        tbl[8]  = '{1, 9, 0, 1, 7, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 4, 4, 1, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[10] = '{1, 4, 0, 7, 7, 0, 0, 0, 0, 0, 0, 2, 0, 2, 2, 0};
        tbl[11] = '{1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0};

        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        check_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].tu_rs, tbl[i].tu_rt,
                  tbl[i].dst, tbl[i].tnew, tbl[i].mu, tbl[i].ms, tbl[i].md);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_frs_d, tbl[i].e_frt_d,
                      tbl[i].e_frs_e, tbl[i].e_frt_e, tbl[i].e_busy);
            next_cycle();
        end
        drive_idle();
        repeat (NSTAGE + 1) next_cycle();

        md_seq(1'b1, "div");
        md_seq(1'b0, "mult");

        // div, two writers, then mflo reading $9; reset lands when the counter is 6
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 5'd1, 5'd0, 3'd1, 3'd7, 5'd7, 3'd3, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd1, 5'd0, 3'd1, 3'd7, 5'd9, 3'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd9, 5'd7, 3'd7, 3'd7, 5'd8, 3'd1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        #1;
        chk("rstdiv.pre_stall", 32'(sb.stall), 32'd1);
        chk("rstdiv.pre_busy", 32'(sb.md_busy), 32'd1);
        chk("rstdiv.pre_fwd_rs_d", 32'(sb.fwd_rs_d), 32'd3);
        reset = 1'b1;
        #1;
        check_all("rstdiv.async", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_all("rstdiv.held", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd9, 5'd7, 3'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_all("rstdiv.after", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        next_cycle();

        reset = 1'b1;
        drive_idle();
        next_cycle();
        reset = 1'b0;
        fl.delete();
        busy_until = -1;
        cyc = 0;
        for (int i = 0; i < 600; i++) begin
            logic v, mu, ms, md;
            logic [4:0] rs, rt, dst;
            int tu_rs, tu_rt, tnew;
            v     = ($urandom_range(0, 3) != 0);
            rs    = 5'($urandom_range(0, 7));
            rt    = 5'($urandom_range(0, 7));
            tu_rs = $urandom_range(0, 7);
            tu_rt = $urandom_range(0, 7);
            dst   = 5'($urandom_range(0, 7));
            tnew  = $urandom_range(0, 3);
            ms    = ($urandom_range(0, 15) == 0);
            md    = $urandom_range(0, 1) != 0;
            mu    = ms || ($urandom_range(0, 5) == 0);
            drive(v, rs, rt, 3'(tu_rs), 3'(tu_rt), dst, 3'(tnew), mu, ms, md);
            model_step(v, rs, rt, tu_rs, tu_rt, dst, tnew, mu, ms, md, $sformatf("rnd%0d", i));
            next_cycle();
            cyc++;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
